// File: rtl/ysyx_22041461_muldiv_iter.sv
// Iterative RV64M multiply/divide unit: radix-2 shift-add multiply and restoring
// divide behind valid/ready handshakes, with flush, W ops and 1-cycle special cases.
module ysyx_22041461_muldiv_iter #(
  parameter int XLEN     = 64,
  parameter bit W_OPS_EN = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      op,
  input  logic [XLEN-1:0] src1,
  input  logic [XLEN-1:0] src2,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);

  localparam int CW = $clog2(XLEN);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  localparam logic [CW-1:0] LAST_X = CW'(XLEN - 1);
  localparam logic [CW-1:0] LAST_W = CW'(31);
  localparam logic [XLEN-1:0] MIN_X = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] MIN_W = {{(XLEN-31){1'b1}}, {31{1'b0}}};

  function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
    logic [XLEN-1:0] r;
    r = {XLEN{v[31]}};
    r[31:0] = v;
    return r;
  endfunction

  function automatic logic [XLEN-1:0] zext32(input logic [31:0] v);
    logic [XLEN-1:0] r;
    r = '0;
    r[31:0] = v;
    return r;
  endfunction

  logic [1:0]        state_q, state_d;
  logic [3:0]        op_q, op_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              neg_q, neg_d, rneg_q, rneg_d;
  logic [2*XLEN-1:0] mcand_q, mcand_d, prod_q, prod_d;
  logic [XLEN-1:0]   mplier_q, mplier_d;
  logic [XLEN-1:0]   divisor_q, divisor_d, quo_q, quo_d, rem_q, rem_d;
  logic [XLEN-1:0]   res_q, res_d;

  // Request decode and operand preparation on the live inputs.
  logic            is_w, is_div, is_rem, legal, s1_signed, s2_signed;
  logic [XLEN-1:0] a_ext, b_ext, a_mag, b_mag, fast_raw, fast_res;
  logic            a_neg, b_neg, div_zero, ovf, fast;

  assign is_w      = op[3];
  assign is_div    = op[2];
  assign is_rem    = op[2] & op[1];
  assign legal     = !op[3] || (W_OPS_EN && (op == 4'd8 || op[2]));
  assign s1_signed = (op == 4'd1) || (op == 4'd2) || (op[2] && !op[0]);
  assign s2_signed = (op == 4'd1) || (op[2] && !op[0]);

  assign a_ext = is_w ? (s1_signed ? sext32(src1[31:0]) : zext32(src1[31:0])) : src1;
  assign b_ext = is_w ? (s2_signed ? sext32(src2[31:0]) : zext32(src2[31:0])) : src2;
  assign a_neg = s1_signed & a_ext[XLEN-1];
  assign b_neg = s2_signed & b_ext[XLEN-1];
  assign a_mag = a_neg ? -a_ext : a_ext;
  assign b_mag = b_neg ? -b_ext : b_ext;

  assign div_zero = (b_ext == '0);
  assign ovf      = op[2] && !op[0] && (b_ext == '1) && (a_ext == (is_w ? MIN_W : MIN_X));
  assign fast     = !legal || (is_div && (div_zero || ovf));

  always_comb begin
    if (!legal)
      fast_raw = '0;
    else if (div_zero)
      fast_raw = is_rem ? a_ext : '1;
    else
      fast_raw = is_rem ? '0 : a_ext;
    fast_res = is_w ? sext32(fast_raw[31:0]) : fast_raw;
  end

  // One radix-2 step of each datapath; only the one matching op_q matters.
  logic [2*XLEN-1:0] step_prod, prod_fix;
  logic [XLEN:0]     rem_sh;
  logic              rem_ge;
  logic [XLEN-1:0]   step_quo, step_rem, quo_fix, rem_fix, fin_raw, fin_res;
  logic [CW-1:0]     last_cnt;

  assign step_prod = mplier_q[0] ? prod_q + mcand_q : prod_q;
  assign rem_sh    = {rem_q, quo_q[XLEN-1]};
  assign rem_ge    = (rem_sh >= {1'b0, divisor_q});
  assign step_quo  = {quo_q[XLEN-2:0], rem_ge};
  assign step_rem  = rem_ge ? (rem_sh[XLEN-1:0] - divisor_q) : rem_sh[XLEN-1:0];
  assign last_cnt  = op_q[3] ? LAST_W : LAST_X;

  always_comb begin
    prod_fix = neg_q ? -step_prod : step_prod;
    quo_fix  = neg_q ? -step_quo : step_quo;
    rem_fix  = rneg_q ? -step_rem : step_rem;
    case (op_q)
      4'd0:                   fin_raw = prod_fix[XLEN-1:0];
      4'd1, 4'd2, 4'd3:       fin_raw = prod_fix[2*XLEN-1:XLEN];
      4'd8:                   fin_raw = step_prod[XLEN-1:0];
      4'd4, 4'd5, 4'd12, 4'd13: fin_raw = quo_fix;
      default:                fin_raw = rem_fix;
    endcase
    fin_res = op_q[3] ? sext32(fin_raw[31:0]) : fin_raw;
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    cnt_d     = cnt_q;
    neg_d     = neg_q;
    rneg_d    = rneg_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    prod_d    = prod_q;
    divisor_d = divisor_q;
    quo_d     = quo_q;
    rem_d     = rem_q;
    res_d     = res_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          op_d      = op;
          cnt_d     = '0;
          neg_d     = a_neg ^ b_neg;
          rneg_d    = a_neg;
          mcand_d   = {{XLEN{1'b0}}, a_mag};
          mplier_d  = b_mag;
          prod_d    = '0;
          divisor_d = b_mag;
          // W dividends start at the top so the quotient lands in the low word.
          quo_d     = is_w ? (a_mag << (XLEN - 32)) : a_mag;
          rem_d     = '0;
          if (fast) begin
            state_d = S_DONE;
            res_d   = fast_res;
          end else begin
            state_d = S_CALC;
          end
        end
      end
      S_CALC: begin
        prod_d   = step_prod;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        quo_d    = step_quo;
        rem_d    = step_rem;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == last_cnt) begin
          state_d = S_DONE;
          res_d   = fin_res;
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (flush) state_d = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      op_q      <= '0;
      cnt_q     <= '0;
      neg_q     <= 1'b0;
      rneg_q    <= 1'b0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      prod_q    <= '0;
      divisor_q <= '0;
      quo_q     <= '0;
      rem_q     <= '0;
      res_q     <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      cnt_q     <= cnt_d;
      neg_q     <= neg_d;
      rneg_q    <= rneg_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      prod_q    <= prod_d;
      divisor_q <= divisor_d;
      quo_q     <= quo_d;
      rem_q     <= rem_d;
      res_q     <= res_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE);
  assign result    = out_valid ? res_q : '0;

endmodule

// File: tb/tb_ysyx_22041461_muldiv_iter.sv
// Directed bench for the iterative mul/div unit: results, latency, backpressure,
// flush and reset aborts against hand-computed RV64M values.
module tb_ysyx_22041461_muldiv_iter;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  op;
  logic [63:0] src1, src2;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] result;
  logic        busy;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  ysyx_22041461_muldiv_iter #(.XLEN(64), .W_OPS_EN(1'b1)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .src1      (src1),
    .src2      (src2),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .busy      (busy)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%h expected 0x%h", tag, got, exp);
    end
  endtask

  // Present a request in the low phase, return #1 after the accept edge with
  // the inputs scrambled so only latched operands can produce the result.
  task automatic issue(input logic [3:0] o, input logic [63:0] a, input logic [63:0] b);
    @(negedge clk);
    chk("rdy_before_issue", {63'd0, in_ready}, 64'd1);
    in_valid = 1'b1;
    op       = o;
    src1     = a;
    src2     = b;
    @(posedge clk); #1;
    in_valid = 1'b0;
    op       = 4'd9;
    src1     = ~a;
    src2     = 64'd0;
  endtask

  // Cycle number (accept edge = T) at which out_valid is first seen, as T+cyc.
  task automatic wait_out(output int cyc);
    cyc = 1;
    while (!out_valid && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic take();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic run(input string tag, input logic [3:0] o, input logic [63:0] a,
                     input logic [63:0] b, input logic [63:0] exp, input int exp_cyc);
    int cyc;
    issue(o, a, b);
    wait_out(cyc);
    chk({tag, "_lat"}, 64'(cyc), 64'(exp_cyc));
    chk(tag, result, exp);
    take();
    chk({tag, "_after"}, {61'd0, out_valid, in_ready, busy}, {61'd0, 3'b010});
  endtask

  typedef struct {
    logic [3:0]  o;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] e;
    int          c;
  } vec_t;

  vec_t vecs [18];

  initial begin
    vecs[0]  = '{4'd0,  64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 65};
    vecs[1]  = '{4'd1,  64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFF, 65};
    vecs[2]  = '{4'd3,  64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'd1, 65};
    vecs[3]  = '{4'd2,  64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 65};
    vecs[4]  = '{4'd4,  64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 65};
    vecs[5]  = '{4'd6,  64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 65};
    vecs[6]  = '{4'd5,  64'd100, 64'd7, 64'd14, 65};
    vecs[7]  = '{4'd7,  64'd100, 64'd7, 64'd2, 65};
    vecs[8]  = '{4'd12, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 1};
    vecs[9]  = '{4'd5,  64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1};
    vecs[10] = '{4'd6,  64'd5, 64'd0, 64'd5, 1};
    vecs[11] = '{4'd15, 64'h0000_0001_8000_0001, 64'd0, 64'hFFFF_FFFF_8000_0001, 1};
    vecs[12] = '{4'd8,  64'h0000_0001_0000_0003, 64'h0000_0000_7FFF_FFFF, 64'h0000_0000_7FFF_FFFD, 33};
    vecs[13] = '{4'd13, 64'h0000_0000_FFFF_FFFE, 64'd1, 64'hFFFF_FFFF_FFFF_FFFE, 33};
    vecs[14] = '{4'd4,  64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 1};
    vecs[15] = '{4'd14, 64'h0000_0000_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 33};
    vecs[16] = '{4'd9,  64'd123, 64'd45, 64'd0, 1};
    vecs[17] = '{4'd14, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 64'd0, 1};
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  cyc;
    bit  seen;
    rst       = 1'b1;
    in_valid  = 1'b0;
    op        = 4'd0;
    src1      = 64'd0;
    src2      = 64'd0;
    flush     = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_state", {60'd0, in_ready, out_valid, busy, 1'b0}, {60'd0, 4'b1000});
    chk("reset_result", result, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 18; i++)
      run($sformatf("vec%0d_op%0d", i, vecs[i].o), vecs[i].o, vecs[i].a, vecs[i].b,
          vecs[i].e, vecs[i].c);

    // Backpressure: hold the result for 10 cycles while a new request waits.
    issue(4'd5, 64'd100, 64'd7);
    wait_out(cyc);
    chk("bp_lat", 64'(cyc), 64'd65);
    for (int k = 0; k < 10; k++) begin
      in_valid = 1'b1;
      op       = 4'd0;
      src1     = 64'd3;
      src2     = 64'd4;
      @(posedge clk); #1;
      chk($sformatf("bp_hold%0d", k), {result[61:0], out_valid, in_ready},
          {62'd14, 1'b1, 1'b0});
    end
    in_valid = 1'b0;
    take();
    chk("bp_release", {61'd0, out_valid, in_ready, busy}, {61'd0, 3'b010});
    run("bp_b2b", 4'd1, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFF, 65);

    // Flush in CALC, with a competing request that must be ignored.
    issue(4'd0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD);
    repeat (19) begin @(posedge clk); #1; end
    flush    = 1'b1;
    in_valid = 1'b1;
    op       = 4'd5;
    src1     = 64'd9;
    src2     = 64'd3;
    @(posedge clk); #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("flush_idle", {61'd0, in_ready, out_valid, busy}, {61'd0, 3'b100});
    seen = 1'b0;
    repeat (80) begin @(posedge clk); #1; if (out_valid) seen = 1'b1; end
    chk("flush_no_result", {63'd0, seen}, 64'd0);
    run("post_flush_mul", 4'd0, 64'd3, 64'd4, 64'd12, 65);

    // Reset in CALC.
    issue(4'd0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD);
    repeat (4) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_idle", {61'd0, in_ready, out_valid, busy}, {61'd0, 3'b100});
    seen = 1'b0;
    repeat (80) begin @(posedge clk); #1; if (out_valid) seen = 1'b1; end
    chk("rst_no_result", {63'd0, seen}, 64'd0);
    run("post_rst_mul", 4'd0, 64'd3, 64'd4, 64'd12, 65);

    // Flush while a result is held, together with out_ready.
    issue(4'd5, 64'd5, 64'd0);
    wait_out(cyc);
    chk("dflush_lat", 64'(cyc), 64'd1);
    flush     = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    flush     = 1'b0;
    out_ready = 1'b0;
    chk("dflush_idle", {60'd0, in_ready, out_valid, busy, 1'b0}, {60'd0, 4'b1000});
    chk("dflush_result", result, 64'd0);
    run("post_dflush_divu", 4'd5, 64'd100, 64'd7, 64'd14, 65);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
